// File: rtl/types_def.sv
// Shared request types and sizing constants for the request mapper front end.
package types_def;

  localparam int read_entries     = 3;
  localparam int write_entries    = 3;
  localparam int read_entries_log = 1;
  localparam int address_width    = 8;
  localparam int data_width       = 16;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } r_type;

  typedef struct packed {
    logic [address_width-1:0] address;
    logic [data_width-1:0]    data;
    r_type                    req_type;
  } request;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mapper_state_t;

endpackage

// File: rtl/slot_allocator.sv
// Free-list for N slots: lowest-free allocation, checked release, occupancy count.
module slot_allocator #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_i,
  input  logic             rel_i,
  input  logic [IDX_W-1:0] rel_idx_i,
  output logic [IDX_W-1:0] alloc_idx_o,
  output logic [IDX_W:0]   free_cnt_o,
  output logic             rel_err_o
);

  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(N);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  logic [N-1:0]     free_q, free_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0] ff_idx_s;
  logic             rel_ok_s;

  // Find-first-free: descending scan so the lowest free slot wins.
  always_comb begin
    ff_idx_s = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (free_q[i]) begin
        ff_idx_s = IDX_W'(i);
      end else begin
        ff_idx_s = ff_idx_s;
      end
    end
  end

  // A release is legal only for an in-range slot that is currently busy.
  always_comb begin
    rel_ok_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rel_i && (rel_idx_i == IDX_W'(i)) && !free_q[i]) begin
        rel_ok_s = 1'b1;
      end else begin
        rel_ok_s = rel_ok_s;
      end
    end
  end

  // Next bitmap and count; allocation works from the pre-release bitmap.
  always_comb begin
    free_d = free_q;
    for (int i = 0; i < N; i++) begin
      if (alloc_i && (ff_idx_s == IDX_W'(i))) begin
        free_d[i] = 1'b0;
      end else if (rel_ok_s && (rel_idx_i == IDX_W'(i))) begin
        free_d[i] = 1'b1;
      end else begin
        free_d[i] = free_q[i];
      end
    end
    case ({alloc_i, rel_ok_s})
      2'b10:   cnt_d = cnt_q - CNT_ONE;
      2'b01:   cnt_d = cnt_q + CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Bitmap and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q <= '1;
      cnt_q  <= CNT_FULL;
    end else begin
      free_q <= free_d;
      cnt_q  <= cnt_d;
    end
  end

  assign alloc_idx_o = ff_idx_s;
  assign free_cnt_o  = cnt_q;
  assign rel_err_o   = rel_i && !rel_ok_s;

endmodule

// File: rtl/request_mapper.sv
// Allocates read/write slot indices for ingress requests and forwards them to
// global_array as a registered one-cycle pulse; tracks slot releases.
module request_mapper
  import types_def::*;
#(
  parameter int RD_ENTRIES = read_entries + 1,
  parameter int WR_ENTRIES = write_entries + 1,
  parameter int IDX_W      = read_entries_log + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  request           in_req,
  output logic             in_ready,
  output logic             mapper_valid,
  output request           out_request,
  output logic [IDX_W-1:0] out_request_index,
  input  logic             rel_valid,
  input  logic [IDX_W-1:0] rel_index,
  input  r_type            rel_type,
  output logic [IDX_W:0]   rd_free_cnt,
  output logic [IDX_W:0]   wr_free_cnt,
  output logic             rel_error
);

  mapper_state_t    state_q, state_d;
  logic             mv_q;
  request           req_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q;

  logic             accept_s, alloc_rd_s, alloc_wr_s, rel_rd_s, rel_wr_s;
  logic             rd_err_s, wr_err_s;
  logic [IDX_W-1:0] rd_idx_s, wr_idx_s;

  // Ready only in RUN and only if the addressed free list is non-empty.
  always_comb begin
    if (state_q == RUN) begin
      if (in_req.req_type == READ) begin
        in_ready = (rd_free_cnt != '0);
      end else begin
        in_ready = (wr_free_cnt != '0);
      end
    end else begin
      in_ready = 1'b0;
    end
  end

  assign accept_s   = in_valid && in_ready;
  assign alloc_rd_s = accept_s && (in_req.req_type == READ);
  assign alloc_wr_s = accept_s && (in_req.req_type == WRITE);
  assign rel_rd_s   = rel_valid && (rel_type == READ);
  assign rel_wr_s   = rel_valid && (rel_type == WRITE);

  slot_allocator #(.N(RD_ENTRIES), .IDX_W(IDX_W)) u_rd_alloc (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (alloc_rd_s),
    .rel_i       (rel_rd_s),
    .rel_idx_i   (rel_index),
    .alloc_idx_o (rd_idx_s),
    .free_cnt_o  (rd_free_cnt),
    .rel_err_o   (rd_err_s)
  );

  slot_allocator #(.N(WR_ENTRIES), .IDX_W(IDX_W)) u_wr_alloc (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (alloc_wr_s),
    .rel_i       (rel_wr_s),
    .rel_idx_i   (rel_index),
    .alloc_idx_o (wr_idx_s),
    .free_cnt_o  (wr_free_cnt),
    .rel_err_o   (wr_err_s)
  );

  // Next-state: INIT is a single settling cycle; slot index follows request type.
  always_comb begin
    case (state_q)
      INIT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
    if (in_req.req_type == READ) begin
      idx_d = rd_idx_s;
    end else begin
      idx_d = wr_idx_s;
    end
  end

  // Output registers; request/index hold their value on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      mv_q    <= 1'b0;
      req_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mv_q    <= accept_s;
      if (accept_s) begin
        req_q <= in_req;
        idx_q <= idx_d;
      end else begin
        req_q <= req_q;
        idx_q <= idx_q;
      end
      err_q <= err_q || rd_err_s || wr_err_s;
    end
  end

  assign mapper_valid      = mv_q;
  assign out_request       = req_q;
  assign out_request_index = idx_q;
  assign rel_error         = err_q;

endmodule

// File: tb/tb_request_mapper.sv
// Directed bench for request_mapper (4 read / 4 write slots).
module tb_request_mapper;
  import types_def::*;

  localparam int IDX_W = read_entries_log + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  request           in_req;
  logic             in_ready;
  logic             mapper_valid;
  request           out_request;
  logic [IDX_W-1:0] out_request_index;
  logic             rel_valid;
  logic [IDX_W-1:0] rel_index;
  r_type            rel_type;
  logic [IDX_W:0]   rd_free_cnt;
  logic [IDX_W:0]   wr_free_cnt;
  logic             rel_error;

  int n_tests;
  int n_fail;

  request_mapper dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_req            (in_req),
    .in_ready          (in_ready),
    .mapper_valid      (mapper_valid),
    .out_request       (out_request),
    .out_request_index (out_request_index),
    .rel_valid         (rel_valid),
    .rel_index         (rel_index),
    .rel_type          (rel_type),
    .rd_free_cnt       (rd_free_cnt),
    .wr_free_cnt       (wr_free_cnt),
    .rel_error         (rel_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input r_type t, input logic [7:0] a);
    in_req.address  = a;
    in_req.data     = {8'hA5, a};
    in_req.req_type = t;
  endtask

  task automatic set_rel(input logic v, input r_type t, input logic [IDX_W-1:0] i);
    rel_valid = v;
    rel_type  = t;
    rel_index = i;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_req    = '0;
    set_rel(1'b0, READ, 2'd0);
    tick();
    tick();
    chk("rst_mv", 32'(mapper_valid), 32'd0);
    chk("rst_rdcnt", 32'(rd_free_cnt), 32'd4);
    chk("rst_wrcnt", 32'(wr_free_cnt), 32'd4);
    chk("rst_err", 32'(rel_error), 32'd0);
    chk("rst_idx", 32'(out_request_index), 32'd0);
    chk("rst_req", 32'(out_request), 32'd0);

    // Three back-to-back reads starting in the first RUN cycle.
    rst = 1'b0;
    in_valid = 1'b1;
    set_req(READ, 8'h01);
    chk("init_ready", 32'(in_ready), 32'd0);
    tick();
    chk("init_no_mv", 32'(mapper_valid), 32'd0);
    chk("run_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd3_mv", 32'(mapper_valid), 32'd1);
      chk("rd3_idx", 32'(out_request_index), 32'(i));
      chk("rd3_addr", 32'(out_request.address), 32'(i + 1));
      chk("rd3_type", 32'(out_request.req_type), 32'(READ));
      set_req(READ, 8'(i + 2));
    end
    in_valid = 1'b0;
    chk("rd3_rdcnt", 32'(rd_free_cnt), 32'd1);
    chk("rd3_wrcnt", 32'(wr_free_cnt), 32'd4);
    tick();
    chk("idle_mv", 32'(mapper_valid), 32'd0);
    chk("idle_idx_hold", 32'(out_request_index), 32'd2);
    chk("idle_addr_hold", 32'(out_request.address), 32'd3);

    // Four writes fill the write list; a fifth waits for a release.
    in_valid = 1'b1;
    set_req(WRITE, 8'h10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr4_mv", 32'(mapper_valid), 32'd1);
      chk("wr4_idx", 32'(out_request_index), 32'(i));
      chk("wr4_data", 32'(out_request.data), 32'({8'hA5, 8'(8'h10 + i)}));
      set_req(WRITE, 8'(8'h11 + i));
    end
    chk("wr5_ready", 32'(in_ready), 32'd0);
    chk("wr_full_cnt", 32'(wr_free_cnt), 32'd0);
    tick();
    chk("wr5_stall_mv", 32'(mapper_valid), 32'd0);
    set_rel(1'b1, WRITE, 2'd2);
    chk("wr5_ready_rel", 32'(in_ready), 32'd0);
    tick();
    set_rel(1'b0, READ, 2'd0);
    chk("wr_rel_cnt", 32'(wr_free_cnt), 32'd1);
    chk("wr5_ready_after", 32'(in_ready), 32'd1);
    chk("wr5_no_mv_yet", 32'(mapper_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("wr5_mv", 32'(mapper_valid), 32'd1);
    chk("wr5_idx", 32'(out_request_index), 32'd2);
    chk("wr5_addr", 32'(out_request.address), 32'h14);
    chk("wr5_cnt", 32'(wr_free_cnt), 32'd0);

    // Fill reads, then release slot 1 while a read waits: no bypass.
    in_valid = 1'b1;
    set_req(READ, 8'h20);
    tick();
    chk("rd4_idx", 32'(out_request_index), 32'd3);
    chk("rd_full_cnt", 32'(rd_free_cnt), 32'd0);
    set_req(READ, 8'h21);
    set_rel(1'b1, READ, 2'd1);
    chk("bypass_ready", 32'(in_ready), 32'd0);
    tick();
    set_rel(1'b0, READ, 2'd0);
    chk("bypass_mv", 32'(mapper_valid), 32'd0);
    chk("bypass_cnt", 32'(rd_free_cnt), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bypass_acc_mv", 32'(mapper_valid), 32'd1);
    chk("bypass_acc_idx", 32'(out_request_index), 32'd1);
    chk("bypass_acc_cnt", 32'(rd_free_cnt), 32'd0);

    // Free slot 0, then release 3 alongside a read: read must get 0, not 3.
    set_rel(1'b1, READ, 2'd0);
    tick();
    chk("rel0_cnt", 32'(rd_free_cnt), 32'd1);
    set_rel(1'b1, READ, 2'd3);
    in_valid = 1'b1;
    set_req(READ, 8'h30);
    tick();
    set_rel(1'b0, READ, 2'd0);
    in_valid = 1'b0;
    chk("same_mv", 32'(mapper_valid), 32'd1);
    chk("same_idx", 32'(out_request_index), 32'd0);
    chk("same_cnt", 32'(rd_free_cnt), 32'd1);
    chk("same_err", 32'(rel_error), 32'd0);

    // Double release of free slot 3 is ignored and sets the sticky error.
    set_rel(1'b1, READ, 2'd3);
    tick();
    set_rel(1'b0, READ, 2'd0);
    chk("dbl_err", 32'(rel_error), 32'd1);
    chk("dbl_cnt", 32'(rd_free_cnt), 32'd1);
    tick();
    tick();
    chk("dbl_err_sticky", 32'(rel_error), 32'd1);

    // Reset in the middle of a burst clears everything immediately.
    in_valid = 1'b1;
    set_req(READ, 8'h40);
    tick();
    chk("burst_mv", 32'(mapper_valid), 32'd1);
    chk("burst_idx", 32'(out_request_index), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mv", 32'(mapper_valid), 32'd0);
    chk("arst_rdcnt", 32'(rd_free_cnt), 32'd4);
    chk("arst_wrcnt", 32'(wr_free_cnt), 32'd4);
    chk("arst_err", 32'(rel_error), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    // Release in INIT of a free slot: flagged, count untouched.
    set_rel(1'b1, READ, 2'd0);
    tick();
    set_rel(1'b0, READ, 2'd0);
    chk("init_rel_err", 32'(rel_error), 32'd1);
    chk("init_rel_cnt", 32'(rd_free_cnt), 32'd4);
    in_valid = 1'b1;
    set_req(READ, 8'h50);
    tick();
    in_valid = 1'b0;
    chk("post_rst_mv", 32'(mapper_valid), 32'd1);
    chk("post_rst_idx", 32'(out_request_index), 32'd0);
    chk("post_rst_cnt", 32'(rd_free_cnt), 32'd3);
    chk("post_rst_err", 32'(rel_error), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/request_mapper.md
Name: request_mapper

Overview:
- Front-end stage directly upstream of global_array.
- Accepts typed requests from the ingress interface and allocates a free slot index from a per-type free list (read or write).
- Forwards request plus index to global_array as a registered, single-cycle mapper_valid pulse.
- Scheduler returns slots via a release interface once it has pulled the request out of global_array; the mapper keeps per-type occupancy counts.

Parameters:
- RD_ENTRIES, read_entries+1 (from types_def): number of read slots.
- WR_ENTRIES, write_entries+1 (from types_def): number of write slots.
- IDX_W, read_entries_log+1: index width; must satisfy 2**IDX_W >= max(RD_ENTRIES, WR_ENTRIES).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  ingress request valid.
- in_req  in  request  ingress request (address, data, req_type).
- in_ready  out  1  ingress may transfer this cycle.
- mapper_valid  out  1  one-cycle pulse to global_array.
- out_request  out  request  registered copy of accepted request.
- out_request_index  out  IDX_W  allocated slot.
- rel_valid  in  1  scheduler releases a slot.
- rel_index  in  IDX_W  released slot.
- rel_type  in  r_type  free list to return it to.
- rd_free_cnt  out  IDX_W+1  free read slots.
- wr_free_cnt  out  IDX_W+1  free write slots.
- rel_error  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync-deassert usage):
  - All read and write slots marked free.
  - rd_free_cnt=RD_ENTRIES, wr_free_cnt=WR_ENTRIES.
  - mapper_valid=0, out_request=0, out_request_index=0, rel_error=0.
  - State=INIT.
- FSM states INIT, RUN:
  - INIT lasts exactly one cycle after rst deasserts; in_ready=0 in INIT.
  - INIT -> RUN unconditionally. No other transitions except reset.
- in_ready (combinational):
  - RUN && (in_req.req_type==read ? rd_free_cnt!=0 : wr_free_cnt!=0).
  - Ingress must not change in_req while in_valid=1 and in_ready=0.
- Accept on edge where in_valid && in_ready:
  - Lowest-numbered free slot of the matching type is allocated and marked busy.
  - Matching count decrements.
  - Next cycle: mapper_valid=1, out_request=in_req, out_request_index=slot.
  - Latency is 1 cycle; back-to-back accepts give back-to-back pulses.
- Idle cycle (no accept): mapper_valid=0; out_request and out_request_index hold their last values.
- Release on edge with rel_valid:
  - Slot rel_index of rel_type is marked free; matching count increments.
  - Release of an already-free slot, or rel_index >= entries of that type: ignored (no state change) and rel_error set. rel_error clears only on rst.
- Simultaneous accept and release of the same type in one edge:
  - Allocator sees the pre-release bitmap; no bypass.
  - A slot released this edge cannot be allocated this edge.
  - Count is unchanged (−1 +1).
  - With 0 free slots, in_ready stays 0 that cycle even though a release arrives.
- Releases accepted in any state, including INIT; they are only legal for busy slots, so any release in INIT flags rel_error.
- Counts never wrap: they are derived from legal updates only; illegal releases do not touch them.
- Reset mid-operation: all in-flight state dropped, mapper_valid forced 0 immediately (async).

Decomposition:
- types_def (shared package) supplies: request, r_type, read_entries, write_entries, read_entries_log, address_width, data_width. Add mapper_state_t enum {INIT, RUN} there.
- One sub-module: slot_allocator, instantiated twice (read, write), parameterised by N. It contains:
  - free bitmap
  - find-first-free encoder
  - count register
  - alloc/release ports
  - error output

Test Plan (RD_ENTRIES=WR_ENTRIES=4 build):
- Reset, then 3 read requests back-to-back from the first RUN cycle -> mapper_valid on 3 consecutive cycles, indices 0,1,2; rd_free_cnt=1; wr_free_cnt=4.
- 4 writes then a 5th write held valid -> indices 0..3; in_ready=0 on the 5th; release write idx 2 -> the 5th is accepted the cycle after release, index 2.
- All 4 reads busy, same cycle release read idx 1 and read in_valid -> no accept that cycle; accepted next cycle with index 1; rd_free_cnt stays 0.
- Read slot 3 busy, then release read idx 3 with simultaneous read accept -> new read gets lowest free slot (not 3); rd_free_cnt unchanged.
- Release read idx 0 while it is free -> rel_error=1, rd_free_cnt unchanged at 4; remains 1 until rst.
- Assert rst mid-burst -> mapper_valid=0 at once; counts return to 4/4; first accept after INIT gets index 0.
